// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared codes, state encodings and status layout for the VDP port controller
//
// Purpose:
//   Command codes carried in the top two bits of the second control byte,
//   VRAM port FSM states, data-port action kinds and status byte bit positions.
package vdp_pkg;

  localparam logic [1:0] CODE_VRAM_RD = 2'd0;
  localparam logic [1:0] CODE_VRAM_WR = 2'd1;
  localparam logic [1:0] CODE_REG_WR  = 2'd2;
  localparam logic [1:0] CODE_CRAM_WR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_REQ = 2'd1,
    ST_RD_REQ = 2'd2
  } vram_state_e;

  // Work items that need exclusive use of the VRAM port.
  typedef enum logic [1:0] {
    ACT_DATA_WR  = 2'd0,
    ACT_DATA_RD  = 2'd1,
    ACT_PREFETCH = 2'd2
  } port_act_e;

  localparam int STAT_FRAME = 7;
  localparam int STAT_OVF   = 6;
  localparam int STAT_COLL  = 5;

  function automatic logic [7:0] status_byte(input logic frame, input logic ovf, input logic coll);
    logic [7:0] s;
    s             = '0;
    s[STAT_FRAME] = frame;
    s[STAT_OVF]   = ovf;
    s[STAT_COLL]  = coll;
    return s;
  endfunction

endpackage

// File: rtl/vdp_vram_port.sv
// rtl/vdp_vram_port.sv - one-at-a-time VRAM request FSM with a 1-deep pending action slot
//
// Purpose:
//   Serialises data-port and prefetch actions onto the VRAM req/ack handshake.
//   An action arriving while an op is outstanding is parked (1 deep) and
//   released to the top once the port is idle again; wait_n stalls the Z80
//   while an action is parked.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   data_wr_edge, data_rd_edge      data-port strobe rising edges
//   prefetch_req                    read-ahead request after a code-0 control write
//   data_i                          Z80 data byte captured with a data write
//   act_valid/act_kind/act_data     action the top must execute this clk
//   issue, issue_we, issue_addr,
//   issue_wdata                     VRAM op launched by the top (only while idle)
//   vram_req/we/addr/wdata, vram_ack  arbiter handshake
//   rd_done                         read op acked; vram_rdata valid this clk
//   wait_n                          low while an action is held back
module vdp_vram_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_wr_edge,
  input  logic              data_rd_edge,
  input  logic              prefetch_req,
  input  logic [7:0]        data_i,
  output logic              act_valid,
  output logic [1:0]        act_kind,
  output logic [7:0]        act_data,
  input  logic              issue,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [7:0]        issue_wdata,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ack,
  output logic              rd_done,
  output logic              wait_n
);

  vram_state_e state_q, state_d;
  logic        pend_valid;
  port_act_e   pend_kind;
  logic [7:0]  pend_data;
  logic        new_evt;
  port_act_e   new_kind;
  logic        idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_valid <= 1'b0;
      pend_kind  <= ACT_DATA_WR;
      pend_data  <= 8'h00;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
    end else begin
      state_q <= state_d;
      if (idle && issue) begin
        vram_addr  <= issue_addr;
        vram_wdata <= issue_wdata;
      end
      if (idle) begin
        // The parked action is handed to the top now; a fresh edge in the
        // same clk takes its place in the slot.
        if (pend_valid) begin
          pend_valid <= new_evt;
          if (new_evt) begin
            pend_kind <= new_kind;
            pend_data <= data_i;
          end
        end
      end else if (new_evt && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_kind  <= new_kind;
        pend_data  <= data_i;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idle      = (state_q == ST_IDLE);
    new_evt   = data_wr_edge | data_rd_edge | prefetch_req;
    new_kind  = data_wr_edge ? ACT_DATA_WR : (data_rd_edge ? ACT_DATA_RD : ACT_PREFETCH);
    act_valid = idle & (pend_valid | new_evt);
    act_kind  = pend_valid ? pend_kind : new_kind;
    act_data  = pend_valid ? pend_data : data_i;
    vram_req  = !idle;
    vram_we   = (state_q == ST_WR_REQ);
    rd_done   = (state_q == ST_RD_REQ) && vram_ack;
    // Stall from the colliding edge itself, then for as long as it is parked.
    wait_n    = ~(pend_valid | (!idle & (data_wr_edge | data_rd_edge)));
    case (state_q)
      ST_IDLE:   if (issue) state_d = issue_we ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ: if (vram_ack) state_d = ST_IDLE;
      ST_RD_REQ: if (vram_ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/vdp_io_ctrl.sv
// rtl/vdp_io_ctrl.sv - Z80-side control/data port controller for the VDP
//
// Purpose:
//   Decodes control/data port strobes into register writes, CRAM writes and
//   VRAM reads/writes. Holds the 2-byte command latch, address/code, the
//   read-ahead buffer and the status flags.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   control_wr/rd, control_i/o         control port (status byte out)
//   data_wr/rd, data_i/o               data port (read-ahead buffer out)
//   wait_n                             Z80 stall
//   frame_set, ovf_set, coll_set       renderer flag pulses
//   frame_ie, int_n                    frame interrupt
//   reg_we, reg_addr, reg_data         VDP register write
//   vram_*                             VRAM arbiter req/ack port
//   cram_we, cram_addr, cram_wdata     palette write
module vdp_io_ctrl
  import vdp_pkg::*;
#(
  parameter  int ADDR_W  = 14,
  parameter  int GG_MODE = 1,
  localparam int CRAM_AW = (GG_MODE != 0) ? 5 : 6,
  localparam int CRAM_DW = (GG_MODE != 0) ? 12 : 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               control_wr,
  input  logic               control_rd,
  input  logic [7:0]         control_i,
  output logic [7:0]         control_o,
  input  logic               data_wr,
  input  logic               data_rd,
  input  logic [7:0]         data_i,
  output logic [7:0]         data_o,
  output logic               wait_n,
  input  logic               frame_set,
  input  logic               ovf_set,
  input  logic               coll_set,
  input  logic               frame_ie,
  output logic               int_n,
  output logic               reg_we,
  output logic [3:0]         reg_addr,
  output logic [7:0]         reg_data,
  output logic               vram_req,
  output logic               vram_we,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [CRAM_DW-1:0] cram_wdata
);

  localparam bit IS_GG = (GG_MODE != 0);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic              ctrl_wr_q, ctrl_rd_q, data_wr_q, data_rd_q;
  logic              ctrl_wr_rise, ctrl_rd_rise, data_wr_rise, data_rd_rise;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        code;
  logic              first;
  logic [7:0]        buffer;
  logic [7:0]        cram_latch;
  logic              frame_flag, ovf_flag, coll_flag;
  logic              clr_q;
  logic              prefetch_q;
  logic              act_valid;
  logic [1:0]        act_kind;
  logic [7:0]        act_data;
  logic              rd_done;
  logic              issue, issue_we;
  logic [CRAM_AW-1:0] cram_addr_nx;
  logic [CRAM_DW-1:0] cram_wdata_nx;

  assign ctrl_wr_rise = control_wr & ~ctrl_wr_q;
  assign ctrl_rd_rise = control_rd & ~ctrl_rd_q;
  assign data_wr_rise = data_wr & ~data_wr_q;
  assign data_rd_rise = data_rd & ~data_rd_q;
  assign int_n        = ~(frame_flag & frame_ie);

  // CRAM writes never touch VRAM; every other data action does.
  assign issue    = act_valid & ~((act_kind == ACT_DATA_WR) && (code == CODE_CRAM_WR));
  assign issue_we = (act_kind == ACT_DATA_WR);

  generate
    if (IS_GG) begin : g_gg
      assign cram_addr_nx  = addr[5:1];
      assign cram_wdata_nx = {act_data[3:0], cram_latch};
    end else begin : g_sms
      assign cram_addr_nx  = {1'b0, addr[4:0]};
      assign cram_wdata_nx = act_data[5:0];
    end
  endgenerate

  vdp_vram_port #(.ADDR_W(ADDR_W)) u_port (
    .clk          (clk),
    .rst          (rst),
    .data_wr_edge (data_wr_rise),
    .data_rd_edge (data_rd_rise),
    .prefetch_req (prefetch_q),
    .data_i       (data_i),
    .act_valid    (act_valid),
    .act_kind     (act_kind),
    .act_data     (act_data),
    .issue        (issue),
    .issue_we     (issue_we),
    .issue_addr   (addr),
    .issue_wdata  (act_data),
    .vram_req     (vram_req),
    .vram_we      (vram_we),
    .vram_addr    (vram_addr),
    .vram_wdata   (vram_wdata),
    .vram_ack     (vram_ack),
    .rd_done      (rd_done),
    .wait_n       (wait_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_wr_q  <= 1'b0;
      ctrl_rd_q  <= 1'b0;
      data_wr_q  <= 1'b0;
      data_rd_q  <= 1'b0;
      addr       <= '0;
      code       <= 2'd0;
      first      <= 1'b0;
      buffer     <= 8'h00;
      cram_latch <= 8'h00;
      frame_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      coll_flag  <= 1'b0;
      clr_q      <= 1'b0;
      prefetch_q <= 1'b0;
      control_o  <= 8'h00;
      data_o     <= 8'h00;
      reg_we     <= 1'b0;
      reg_addr   <= 4'h0;
      reg_data   <= 8'h00;
      cram_we    <= 1'b0;
      cram_addr  <= '0;
      cram_wdata <= '0;
    end else begin
      ctrl_wr_q  <= control_wr;
      ctrl_rd_q  <= control_rd;
      data_wr_q  <= data_wr;
      data_rd_q  <= data_rd;
      reg_we     <= 1'b0;
      cram_we    <= 1'b0;
      prefetch_q <= 1'b0;
      clr_q      <= 1'b0;

      // A set pulse landing in the clear clk survives the clear.
      if (clr_q) begin
        frame_flag <= frame_set;
        ovf_flag   <= ovf_set;
        coll_flag  <= coll_set;
        first      <= 1'b0;
      end else begin
        frame_flag <= frame_flag | frame_set;
        ovf_flag   <= ovf_flag | ovf_set;
        coll_flag  <= coll_flag | coll_set;
      end

      if (rd_done) buffer <= vram_rdata;

      if (ctrl_rd_rise) begin
        control_o <= status_byte(frame_flag, ovf_flag, coll_flag);
        clr_q     <= 1'b1;
      end

      if (ctrl_wr_rise) begin
        if (!first) begin
          addr[7:0] <= control_i;
          first     <= 1'b1;
        end else begin
          code             <= control_i[7:6];
          addr[ADDR_W-1:8] <= control_i[ADDR_W-9:0];
          first            <= 1'b0;
          case (control_i[7:6])
            // Delayed one clk so the prefetch sees the new high address byte.
            CODE_VRAM_RD: prefetch_q <= 1'b1;
            CODE_REG_WR: begin
              reg_we   <= 1'b1;
              reg_addr <= control_i[3:0];
              reg_data <= addr[7:0];
            end
            default: ;
          endcase
        end
      end

      if (act_valid) begin
        addr <= addr + ADDR_ONE;
        case (act_kind)
          ACT_DATA_WR: begin
            first <= 1'b0;
            if (code == CODE_CRAM_WR) begin
              // GG colours are 12 bits: even address holds the low byte.
              if (IS_GG && !addr[0]) begin
                cram_latch <= act_data;
              end else begin
                cram_we    <= 1'b1;
                cram_addr  <= cram_addr_nx;
                cram_wdata <= cram_wdata_nx;
              end
            end else begin
              buffer <= act_data;
            end
          end
          ACT_DATA_RD: begin
            first  <= 1'b0;
            data_o <= buffer;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
